// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, special instruction
// encodings and the fetch run-control state encoding.
package mips_pkg;

  localparam int NB_REG = 32;

  localparam logic [NB_REG-1:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [NB_REG-1:0] NOP_WORD  = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_IDLE = 2'b00,
    IF_RUN  = 2'b01,
    IF_HALT = 2'b10
  } if_state_t;

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction RAM: combinational read, synchronous write.
// Contents have no reset so a loaded program survives a pipeline reset.
module instr_mem #(
  parameter int NB_REG    = 32,
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [NB_REG-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [NB_REG-1:0] rdata
);

  logic [NB_REG-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC register, next-PC selection, run-control FSM and the
// instruction memory. Build option IF_MISALIGN_TRAP_EN halts on unaligned targets.
module instruction_fetch #(
  parameter int                     NB_REG    = mips_pkg::NB_REG,
  parameter int                     MEM_DEPTH = 256,
  parameter int                     ADDR_W    = 8,
  parameter logic [NB_REG-1:0]      HALT_WORD = mips_pkg::HALT_WORD
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_dunit_clk_en,
  input  logic              i_start,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [NB_REG-1:0] i_load_data,
  input  logic              i_pc_write,
  input  logic              i_jump,
  input  logic [NB_REG-1:0] i_jump_addr,
  input  logic              i_branch,
  input  logic [NB_REG-1:0] i_branch_addr,
  output logic [NB_REG-1:0] o_pc,
  output logic [NB_REG-1:0] o_pc_four,
  output logic [NB_REG-1:0] o_instruction,
  output logic              o_halt,
  output logic [1:0]        o_state
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic              o_misalign
`endif
);

  import mips_pkg::*;

  if_state_t         state;
  logic [NB_REG-1:0] pc;
  logic [NB_REG-1:0] pc_four;
  logic [NB_REG-1:0] mem_word;
  logic [NB_REG-1:0] fetched;
  logic [NB_REG-1:0] next_pc;
  logic              halt;
  logic              halt_hit;
  logic              load_we;
`ifdef IF_MISALIGN_TRAP_EN
  logic              misalign;
  logic              misalign_hit;
  logic [NB_REG-1:0] target;
`endif

  assign load_we = i_load_en && (state == IF_IDLE);

  instr_mem #(
    .NB_REG   (NB_REG),
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W   (ADDR_W)
  ) u_instr_mem (
    .clk  (i_clk),
    .we   (load_we),
    .waddr(i_load_addr),
    .wdata(i_load_data),
    .raddr(pc[ADDR_W+1:2]),
    .rdata(mem_word)
  );

  // Addresses past the end of memory fetch a NOP instead of aliasing.
  assign fetched  = (pc[NB_REG-1:ADDR_W+2] == '0) ? mem_word : '0;
  assign halt_hit = (fetched == HALT_WORD);
  assign pc_four  = pc + NB_REG'(4);

  always_comb begin
    next_pc = pc_four;
    if (i_jump)        next_pc = i_jump_addr;
    else if (i_branch) next_pc = i_branch_addr;
  end

`ifdef IF_MISALIGN_TRAP_EN
  assign target       = i_jump ? i_jump_addr : i_branch_addr;
  assign misalign_hit = (i_jump || i_branch) && (target[1:0] != 2'b00);
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IF_IDLE;
      pc    <= '0;
      halt  <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IF_IDLE: begin
          if (i_start) state <= IF_RUN;
        end
        IF_RUN: begin
          if (i_dunit_clk_en) begin
            if (halt_hit) begin
              state <= IF_HALT;
              halt  <= 1'b1;
            end
`ifdef IF_MISALIGN_TRAP_EN
            else if (i_pc_write && misalign_hit) begin
              state    <= IF_HALT;
              halt     <= 1'b1;
              misalign <= 1'b1;
            end
`endif
            else if (i_pc_write) begin
              pc <= next_pc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outside RUN the IF/ID register is fed bubbles.
  assign o_instruction = (state == IF_RUN) ? fetched : NOP_WORD;
  assign o_pc          = pc;
  assign o_pc_four     = pc_four;
  assign o_halt        = halt;
  assign o_state       = state;
`ifdef IF_MISALIGN_TRAP_EN
  assign o_misalign    = misalign;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed scenarios then random traffic,
// checked against a behavioural model of the fetch stage.
module tb_instruction_fetch;

  localparam int          MEM_DEPTH = 256;
  localparam logic [31:0] HALT      = 32'hFFFF_FFFF;
  localparam int          S_IDLE = 0, S_RUN = 1, S_HALT = 2;

  logic        clk = 1'b0;
  logic        i_reset, i_dunit_clk_en, i_start, i_load_en;
  logic [7:0]  i_load_addr;
  logic [31:0] i_load_data;
  logic        i_pc_write, i_jump, i_branch;
  logic [31:0] i_jump_addr, i_branch_addr;
  logic [31:0] o_pc, o_pc_four, o_instruction;
  logic        o_halt;
  logic [1:0]  o_state;
  logic        o_misalign;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .i_clk         (clk),
    .i_reset       (i_reset),
    .i_dunit_clk_en(i_dunit_clk_en),
    .i_start       (i_start),
    .i_load_en     (i_load_en),
    .i_load_addr   (i_load_addr),
    .i_load_data   (i_load_data),
    .i_pc_write    (i_pc_write),
    .i_jump        (i_jump),
    .i_jump_addr   (i_jump_addr),
    .i_branch      (i_branch),
    .i_branch_addr (i_branch_addr),
    .o_pc          (o_pc),
    .o_pc_four     (o_pc_four),
    .o_instruction (o_instruction),
    .o_halt        (o_halt),
    .o_state       (o_state)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .o_misalign    (o_misalign)
`endif
  );

`ifndef IF_MISALIGN_TRAP_EN
  assign o_misalign = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        halt;
    logic [1:0]  st;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  logic [31:0] m_mem [MEM_DEPTH];
  logic [31:0] m_pc  = '0;
  int          m_st  = S_IDLE;
  bit          m_mis = 1'b0;

  function automatic logic [31:0] m_fetch();
    if (m_pc < 32'(MEM_DEPTH * 4)) return m_mem[m_pc / 4];
    return 32'h0;
  endfunction

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom_range(0, 1023) & 32'hFFFF_FFFC;
    if ($urandom % 8 == 0)  t = t | 32'($urandom % 4);
    if ($urandom % 32 == 0) t = $urandom;
    return t;
  endfunction

  task automatic step(input bit rst, input bit st, input bit ld,
                      input logic [7:0] la, input logic [31:0] ldd,
                      input bit ce, input bit pw, input bit j,
                      input logic [31:0] ja, input bit b,
                      input logic [31:0] ba, input bit chk);
    exp_t        e;
    logic [31:0] tgt;
    @(negedge clk);
    i_reset = rst; i_start = st; i_load_en = ld; i_load_addr = la;
    i_load_data = ldd; i_dunit_clk_en = ce; i_pc_write = pw;
    i_jump = j; i_jump_addr = ja; i_branch = b; i_branch_addr = ba;
    if (chk) begin
      e.pc    = m_pc;
      e.pc4   = m_pc + 32'd4;
      e.instr = (m_st == S_RUN) ? m_fetch() : 32'h0;
      e.halt  = (m_st == S_HALT);
      e.st    = 2'(m_st);
      e.mis   = m_mis;
      sb.push_back(e);
    end
    if (rst) begin
      m_pc = '0; m_st = S_IDLE; m_mis = 1'b0;
    end else if (m_st == S_IDLE) begin
      if (ld) m_mem[la] = ldd;
      if (st) m_st = S_RUN;
    end else if (m_st == S_RUN && ce) begin
      if (m_fetch() == HALT) m_st = S_HALT;
      else if (pw) begin
        tgt = j ? ja : (b ? ba : m_pc + 32'd4);
`ifdef IF_MISALIGN_TRAP_EN
        if ((j || b) && tgt[1:0] != 2'b00) begin
          m_st = S_HALT; m_mis = 1'b1;
        end else
`endif
        m_pc = tgt;
      end
    end
  endtask

  task automatic t_reset(input bit chk);
    step(1, 0, 0, 8'd0, 32'd0, 1, 1, 0, 32'd0, 0, 32'd0, chk);
  endtask
  task automatic t_load(input logic [7:0] a, input logic [31:0] d);
    step(0, 0, 1, a, d, 1, 1, 0, 32'd0, 0, 32'd0, 1);
  endtask
  task automatic t_start();
    step(0, 1, 0, 8'd0, 32'd0, 1, 1, 0, 32'd0, 0, 32'd0, 1);
  endtask
  task automatic t_run(input bit ce, input bit pw, input bit j,
                       input logic [31:0] ja, input bit b, input logic [31:0] ba);
    step(0, 0, 0, 8'd0, 32'd0, ce, pw, j, ja, b, ba, 1);
  endtask

  function automatic void cmp(input string name, input logic [31:0] act,
                              input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  // Monitor: outputs are stable mid-cycle, pop one expectation per cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("pc",          o_pc,                 e.pc);
        cmp("pc_four",     o_pc_four,            e.pc4);
        cmp("instruction", o_instruction,        e.instr);
        cmp("halt",        32'(o_halt),          32'(e.halt));
        cmp("state",       32'(o_state),         32'(e.st));
        cmp("misalign",    32'(o_misalign),      32'(e.mis));
      end
    end
  end

  initial begin
    i_reset = 1'b1; i_start = 1'b0; i_load_en = 1'b0; i_load_addr = '0;
    i_load_data = '0; i_dunit_clk_en = 1'b0; i_pc_write = 1'b1;
    i_jump = 1'b0; i_jump_addr = '0; i_branch = 1'b0; i_branch_addr = '0;

    t_reset(0);
    t_reset(1);
    for (int i = 0; i < MEM_DEPTH; i++) t_load(8'(i), rnd_word());
    t_load(8'd0, 32'h2008_0005);
    t_load(8'd1, 32'h2009_0003);
    t_load(8'd2, HALT);

    // Short program ending in the halt word; start is ignored once halted
    t_start();
    for (int i = 0; i < 3; i++) t_run(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'd0, 32'd0, 1, 1, 1, 32'h40, 0, 32'd0, 1);

    // Stall priority, jump/branch priority, clock enable, load in RUN
    t_reset(1);
    t_load(8'd2, 32'h2000_0002);
    t_start();
    for (int i = 0; i < 4; i++) t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 0, 1, 32'h40, 0, 0);
    t_run(1, 0, 1, 32'h40, 0, 0);
    t_run(1, 1, 1, 32'h40, 0, 0);
    t_run(1, 1, 1, 32'h80, 1, 32'h20);
    t_run(1, 1, 0, 0, 1, 32'h20);
    for (int i = 0; i < 3; i++) t_run(0, 1, 1, 32'h100, 1, 32'h200);
    step(0, 0, 1, 8'd5, HALT, 0, 1, 0, 32'd0, 0, 32'd0, 1);
    step(0, 0, 1, 8'd6, HALT, 1, 1, 0, 32'd0, 0, 32'd0, 1);
    t_run(1, 1, 1, 32'h14, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 1, 1, 32'h1000, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 1, 1, 32'hFFFF_FFFC, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);

    // Reset mid-run keeps the program; restart from 0
    t_reset(1);
    t_start();
    for (int i = 0; i < 3; i++) t_run(1, 1, 0, 0, 0, 0);
    t_reset(1);
    t_start();
    for (int i = 0; i < 5; i++) t_run(1, 1, 0, 0, 0, 0);

    // Unaligned branch target
    t_run(1, 1, 0, 0, 1, 32'h22);
    t_run(1, 1, 0, 0, 0, 0);
    t_run(1, 1, 0, 0, 0, 0);

    // Random traffic
    t_reset(1);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 100) == 0, ($urandom % 8) == 0, ($urandom % 3) == 0,
           8'($urandom), (($urandom % 32) == 0) ? HALT : rnd_word(),
           ($urandom % 4) != 0, ($urandom % 5) != 0, ($urandom % 6) == 0,
           rnd_tgt(), ($urandom % 4) == 0, rnd_tgt(), 1);
    end

    @(negedge clk);
    #5;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
